multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Control FSM for the multicycle RV32I core. It sequences fetch, decode, execute and writeback over the shared ALU, memory port and register file. It drives ImmSrc to the immediate generator and stalls on a memory ready handshake. It also keeps a retired-instruction counter and a sticky illegal-instruction flag.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
op  in  7  opcode field from the instruction register
funct3  in  3  instruction funct3
funct7b5  in  1  instruction bit 30
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
PCWrite  out  1  PC register write enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register and OldPC write enable
ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = RegA, 11 = zero
ALUSrcB  out  2  ALU B mux: 00 = RegB, 01 = ImmExt, 10 = constant 4
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  out  3  I = 000, S = 001, U = 010, B = 101, J = 110
RegWrite  out  1  register file write enable
illegal  out  1  sticky flag, set on an unsupported instruction
instret  out  CNT_W  count of retired instructions

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: state goes to FETCH, instret clears to 0, illegal clears to 0. While rst is high, all write enables (PCWrite, IRWrite, MemWrite, RegWrite) are forced to 0.
- Output timing: Moore-style, decoded combinationally from the state register. The only exceptions are the mem_ready and zero qualifiers noted below.
- ImmSrc: a pure function of op, valid in every state.
  - 0000011 (load) and 0010011 (OP-IMM) give I.
  - 0100011 (store) gives S. 1100011 (branch) gives B. 0110111 (LUI) gives U. 1101111 (JAL) gives J.
  - Any other op gives 000.
- States, encoded in 4 bits:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite and PCWrite equal mem_ready. Stay in FETCH while mem_ready=0, else go to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (computes the branch target into ALUOut). Next state by op:
    - load or store: MEMADR. R-type 0110011: EXECR. OP-IMM: EXECI.
    - branch: BRANCH. JAL: JAL. LUI: LUI. Anything else: ERROR.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Go to MEMREAD for a load, MEMWRITE for a store.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Hold while mem_ready=0, else go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready. On mem_ready go to FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from the ALU decode. Go to ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALU decode with funct7b5 ignored. Go to ALUWB.
  - LUI: ALUSrcA=11, ALUSrcB=01, add. Go to ALUWB.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
    - funct3 000 (beq): PCWrite=zero. funct3 001 (bne): PCWrite=!zero. Then go to FETCH.
    - Any other funct3: PCWrite=0, go to ERROR.
  - ERROR: all enables 0, illegal=1. Exit only through reset.
- ALU decode (funct3 to ALUControl):
  - 000: sub if R-type and funct7b5=1, else add.
  - 010 gives slt, 110 gives or, 111 gives and.
  - Any other funct3 in EXECR or EXECI: transition goes to ERROR instead of ALUWB.
- instret increments by 1 in the last cycle of an instruction: MEMWB, ALUWB, BRANCH (beq/bne only), and MEMWRITE with mem_ready=1. It wraps modulo 2^CNT_W.
- Latency with mem_ready tied to 1: load 5 cycles; R, I, LUI, JAL and store 4 cycles; branch 3 cycles.
- Reset mid-instruction: state returns to FETCH at once and no partial write occurs.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the state enum;
  - opcode constants;
  - ImmSrc, ALUControl, ResultSrc, ALUSrcA and ALUSrcB encodings, shared with the immediate generator and datapath.
- One combinational sub-module, ctrl_decoder: op, funct3 and funct7b5 in; ImmSrc, ALUControl and a legality flag out.

Test Plan:
- lw with mem_ready=1: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB in 5 cycles; ImmSrc=000; RegWrite=1 only in cycle 5; instret goes 0 to 1.
- sw with mem_ready low for 3 cycles in MEMWRITE: MemWrite=1 for 4 cycles; ImmSrc=001; instret increments only on the ready cycle.
- beq with zero=1, then with zero=0: PCWrite=1, then 0, in the BRANCH cycle; ImmSrc=101; 3 cycles each.
- jal: ImmSrc=110; PCWrite=1 in JAL; RegWrite=1 in ALUWB; back to FETCH after 4 cycles.
- op=7'b1111111: ERROR reached after DECODE; illegal=1 and all enables 0 for 10+ cycles; instret unchanged.
- rst asserted in MEMREAD: state is FETCH asynchronously, instret=0, no RegWrite pulse; the next lui completes normally with ImmSrc=010.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// and the mux/ALU/immediate select codes seen by the datapath and immediate generator.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_LUI      = 4'd8,
      S_JAL      = 4'd9,
      S_ALUWB    = 4'd10,
      S_BRANCH   = 4'd11,
      S_ERROR    = 4'd12
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_U = 3'b010;
   localparam logic [2:0] IMM_B = 3'b101;
   localparam logic [2:0] IMM_J = 3'b110;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REGA  = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_REGB = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_decoder.sv
// Combinational instruction decode: immediate format, ALU operation, and whether
// the op/funct3 combination is one this core implements.
module ctrl_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   output logic [2:0] imm_src_o,
   output logic [2:0] alu_ctrl_o,
   output logic       legal_o
);

   logic alu_f3_ok;

   always_comb begin
      imm_src_o = IMM_I;
      case (op_i)
         OP_LOAD, OP_IMM: imm_src_o = IMM_I;
         OP_STORE:        imm_src_o = IMM_S;
         OP_BRANCH:       imm_src_o = IMM_B;
         OP_LUI:          imm_src_o = IMM_U;
         OP_JAL:          imm_src_o = IMM_J;
         default:         imm_src_o = IMM_I;
      endcase
   end

   // funct7b5 selects sub only for R-type; OP-IMM add ignores it
   always_comb begin
      alu_ctrl_o = ALU_ADD;
      alu_f3_ok  = 1'b1;
      case (funct3_i)
         3'b000:  alu_ctrl_o = (funct7b5_i && op_i == OP_RTYPE) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_ctrl_o = ALU_SLT;
         3'b110:  alu_ctrl_o = ALU_OR;
         3'b111:  alu_ctrl_o = ALU_AND;
         default: alu_f3_ok  = 1'b0;
      endcase
   end

   always_comb begin
      legal_o = 1'b0;
      case (op_i)
         OP_RTYPE, OP_IMM:                 legal_o = alu_f3_ok;
         OP_BRANCH:                        legal_o = (funct3_i == 3'b000) || (funct3_i == 3'b001);
         OP_LOAD, OP_STORE, OP_LUI, OP_JAL: legal_o = 1'b1;
         default:                          legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with memory-ready stalls, a retired-instruction
// counter and a sticky illegal-instruction flag.
module multicycle_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ALUControl,
   output logic [2:0]       ImmSrc,
   output logic             RegWrite,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   state_t             state_q, state_d;
   logic               illegal_q;
   logic [CNT_W-1:0]   instret_q;
   logic [2:0]         dec_alu;
   logic               dec_legal;
   logic               pcw, irw, mw, rw, retire;

   ctrl_decoder u_dec (
      .op_i       (op),
      .funct3_i   (funct3),
      .funct7b5_i (funct7b5),
      .imm_src_o  (ImmSrc),
      .alu_ctrl_o (dec_alu),
      .legal_o    (dec_legal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_q | (state_d == S_ERROR);
         if (retire) instret_q <= instret_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      pcw        = 1'b0;
      irw        = 1'b0;
      mw         = 1'b0;
      rw         = 1'b0;
      retire     = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_REGB;
      ALUControl = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            irw       = mem_ready;
            pcw       = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_IMM:            state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_LUI:            state_d = S_LUI;
               default:           state_d = S_ERROR;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_IMM;
            state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            rw        = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            mw     = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXECR: begin
            ALUSrcA    = SRCA_REGA;
            ALUControl = dec_alu;
            state_d    = dec_legal ? S_ALUWB : S_ERROR;
         end
         S_EXECI: begin
            ALUSrcA    = SRCA_REGA;
            ALUSrcB    = SRCB_IMM;
            ALUControl = dec_alu;
            state_d    = dec_legal ? S_ALUWB : S_ERROR;
         end
         S_LUI: begin
            ALUSrcA = SRCA_ZERO;
            ALUSrcB = SRCB_IMM;
            state_d = S_ALUWB;
         end
         S_JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            pcw     = 1'b1;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            rw      = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA    = SRCA_REGA;
            ALUControl = ALU_SUB;
            // legal funct3 is only beq (000) or bne (001), so bit 0 inverts the test
            if (dec_legal) begin
               pcw     = zero ^ funct3[0];
               retire  = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_ERROR;
            end
         end
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_FETCH;
      endcase
   end

   assign PCWrite  = pcw & ~rst;
   assign IRWrite  = irw & ~rst;
   assign MemWrite = mw  & ~rst;
   assign RegWrite = rw  & ~rst;
   assign illegal  = illegal_q;
   assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected outputs derived from
// instruction-level rules, checked by an independent negedge monitor.
module tb_multicycle_ctrl;

   localparam int CW = 4;
   localparam logic [6:0] LD = 7'b0000011, IM = 7'b0010011, ST = 7'b0100011,
                          RT = 7'b0110011, LU = 7'b0110111, BR = 7'b1100011,
                          JL = 7'b1101111, BAD = 7'b1111111;
   localparam logic [3:0] EN_NONE = 4'b0000, EN_PCIR = 4'b1100, EN_PC = 4'b1000,
                          EN_MW = 4'b0010, EN_RW = 4'b0001;

   logic          clk = 1'b0, rst = 1'b1;
   logic [6:0]    op = '0;
   logic [2:0]    funct3 = '0;
   logic          funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b1;
   logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
   logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0]    ALUControl, ImmSrc;
   logic [CW-1:0] instret;

   multicycle_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
      .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal), .instret(instret)
   );

   always #5 clk = ~clk;

   // -1 in a field means the output is unconstrained in that cycle
   typedef struct {
      int pcw, irw, mw, rw, adr, rs, asa, asb, alu, imm, ill, cnt;
   } exp_t;

   exp_t       sbq[$];
   int         checks = 0, failures = 0;
   int         cnt_m = 0;
   logic [6:0] cur_op = '0;
   logic [2:0] cur_f3 = '0;
   logic       cur_f7 = 1'b0, cur_z = 1'b0;

   function automatic int imm_of(input logic [6:0] o);
      if (o == LD || o == IM) return 0;
      if (o == ST) return 1;
      if (o == LU) return 2;
      if (o == BR) return 5;
      if (o == JL) return 6;
      return 0;
   endfunction

   task automatic chk(input string name, input int got, input int expv);
      if (expv >= 0) begin
         checks++;
         if (got != expv) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, expv);
         end
      end
   endtask

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         chk("PCWrite",    int'(PCWrite),    e.pcw);
         chk("IRWrite",    int'(IRWrite),    e.irw);
         chk("MemWrite",   int'(MemWrite),   e.mw);
         chk("RegWrite",   int'(RegWrite),   e.rw);
         chk("AdrSrc",     int'(AdrSrc),     e.adr);
         chk("ResultSrc",  int'(ResultSrc),  e.rs);
         chk("ALUSrcA",    int'(ALUSrcA),    e.asa);
         chk("ALUSrcB",    int'(ALUSrcB),    e.asb);
         chk("ALUControl", int'(ALUControl), e.alu);
         chk("ImmSrc",     int'(ImmSrc),     e.imm);
         chk("illegal",    int'(illegal),    e.ill);
         chk("instret",    int'(instret),    e.cnt);
      end
   end

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   task automatic cyc(input logic rdy, input logic [3:0] en, input int adr, input int rs,
                      input int asa, input int asb, input int alu, input bit retire, input bit ill);
      exp_t e;
      @(posedge clk);
      #1;
      op = cur_op; funct3 = cur_f3; funct7b5 = cur_f7; zero = cur_z; mem_ready = rdy;
      e.pcw = int'(en[3]); e.irw = int'(en[2]); e.mw = int'(en[1]); e.rw = int'(en[0]);
      e.adr = adr; e.rs = rs; e.asa = asa; e.asb = asb; e.alu = alu;
      e.imm = imm_of(cur_op); e.ill = int'(ill); e.cnt = cnt_m;
      sbq.push_back(e);
      if (retire) cnt_m = (cnt_m + 1) % (1 << CW);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst = 1'b1;
      mem_ready = 1'b1;
      #1;
      chk("rst_PCWrite",  int'(PCWrite),  0);
      chk("rst_IRWrite",  int'(IRWrite),  0);
      chk("rst_MemWrite", int'(MemWrite), 0);
      chk("rst_RegWrite", int'(RegWrite), 0);
      chk("rst_instret",  int'(instret),  0);
      chk("rst_illegal",  int'(illegal),  0);
      chk("rst_fetchB",   int'(ALUSrcB),  2);
      chk("rst_fetchRes", int'(ResultSrc), 2);
      @(posedge clk);
      #1;
      chk("rst_edge_PCWrite", int'(PCWrite), 0);
      chk("rst_edge_IRWrite", int'(IRWrite), 0);
      rst = 1'b0;
      mem_ready = 1'b0;
      cnt_m = 0;
   endtask

   task automatic fetch(input int stalls);
      repeat (stalls) cyc(1'b0, EN_NONE, 0, 2, 0, 2, 0, 0, 0);
      cyc(1'b1, EN_PCIR, 0, 2, 0, 2, 0, 0, 0);
   endtask

   task automatic error_path(input int n);
      repeat (n) cyc(rb(), EN_NONE, -1, -1, -1, -1, -1, 0, 1);
      do_reset();
   endtask

   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input int fst, input int mst, input int errn);
      bit ok;
      int aluv;
      cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_z = z;
      fetch(fst);
      cyc(rb(), EN_NONE, -1, -1, 1, 1, 0, 0, 0);
      if (o == LD || o == ST) begin
         cyc(rb(), EN_NONE, -1, -1, 2, 1, 0, 0, 0);
         if (o == LD) begin
            repeat (mst) cyc(1'b0, EN_NONE, 1, 0, -1, -1, -1, 0, 0);
            cyc(1'b1, EN_NONE, 1, 0, -1, -1, -1, 0, 0);
            cyc(rb(), EN_RW, -1, 1, -1, -1, -1, 1, 0);
         end else begin
            repeat (mst) cyc(1'b0, EN_MW, 1, 0, -1, -1, -1, 0, 0);
            cyc(1'b1, EN_MW, 1, 0, -1, -1, -1, 1, 0);
         end
      end else if (o == RT || o == IM) begin
         ok = 1'b1;
         case (f3)
            3'b000:  aluv = (o == RT && f7) ? 1 : 0;
            3'b010:  aluv = 5;
            3'b110:  aluv = 3;
            3'b111:  aluv = 2;
            default: begin aluv = -1; ok = 1'b0; end
         endcase
         cyc(rb(), EN_NONE, -1, -1, 2, (o == RT) ? 0 : 1, aluv, 0, 0);
         if (ok) cyc(rb(), EN_RW, -1, 0, -1, -1, -1, 1, 0);
         else    error_path(errn);
      end else if (o == LU) begin
         cyc(rb(), EN_NONE, -1, -1, 3, 1, 0, 0, 0);
         cyc(rb(), EN_RW, -1, 0, -1, -1, -1, 1, 0);
      end else if (o == JL) begin
         cyc(rb(), EN_PC, -1, 0, 1, 2, 0, 0, 0);
         cyc(rb(), EN_RW, -1, 0, -1, -1, -1, 1, 0);
      end else if (o == BR) begin
         if (f3 == 3'b000 || f3 == 3'b001) begin
            ok = (f3 == 3'b000) ? z : !z;
            cyc(rb(), ok ? EN_PC : EN_NONE, -1, 0, 2, 0, 1, 1, 0);
         end else begin
            cyc(rb(), EN_NONE, -1, 0, 2, 0, 1, 0, 0);
            error_path(errn);
         end
      end else begin
         error_path(errn);
      end
   endtask

   initial begin
      logic [6:0] ops[8];
      logic [2:0] af3[4];
      ops = '{LD, ST, RT, IM, LU, JL, BR, BAD};
      af3 = '{3'b000, 3'b010, 3'b110, 3'b111};
      #2;
      chk("init_PCWrite", int'(PCWrite), 0);
      chk("init_IRWrite", int'(IRWrite), 0);
      chk("init_instret", int'(instret), 0);
      chk("init_illegal", int'(illegal), 0);
      do_reset();

      run_instr(LD, 3'b010, 1'b0, 1'b0, 0, 0, 2);
      run_instr(ST, 3'b010, 1'b0, 1'b0, 0, 3, 2);
      run_instr(BR, 3'b000, 1'b0, 1'b1, 0, 0, 2);
      run_instr(BR, 3'b000, 1'b0, 1'b0, 0, 0, 2);
      run_instr(BR, 3'b001, 1'b0, 1'b0, 1, 0, 2);
      run_instr(JL, 3'b000, 1'b0, 1'b0, 0, 0, 2);
      run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0, 2);
      run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0, 2);
      run_instr(IM, 3'b000, 1'b1, 1'b0, 0, 0, 2);
      run_instr(RT, 3'b111, 1'b0, 1'b0, 0, 0, 2);
      run_instr(IM, 3'b110, 1'b0, 1'b0, 0, 0, 2);
      run_instr(RT, 3'b010, 1'b0, 1'b0, 2, 0, 2);

      // reset while a load is stalled in its read cycle
      cur_op = LD; cur_f3 = 3'b010; cur_f7 = 1'b0; cur_z = 1'b0;
      fetch(0);
      cyc(rb(), EN_NONE, -1, -1, 1, 1, 0, 0, 0);
      cyc(rb(), EN_NONE, -1, -1, 2, 1, 0, 0, 0);
      cyc(1'b0, EN_NONE, 1, 0, -1, -1, -1, 0, 0);
      do_reset();
      run_instr(LU, 3'b000, 1'b0, 1'b0, 0, 0, 2);

      run_instr(BAD, 3'b000, 1'b0, 1'b0, 0, 0, 12);
      run_instr(RT, 3'b001, 1'b0, 1'b0, 0, 0, 3);
      run_instr(BR, 3'b100, 1'b0, 1'b0, 0, 0, 3);

      // counter wrap with a narrow CNT_W
      repeat (18) run_instr(LU, 3'($urandom_range(0, 7)), 1'b0, 1'b0, 0, 0, 2);

      for (int n = 0; n < 200; n++) begin
         logic [6:0] o;
         logic [2:0] f3;
         o  = ops[$urandom_range(0, 7)];
         f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : af3[$urandom_range(0, 3)];
         if (o == BR && $urandom_range(0, 7) != 0) f3 = 3'($urandom_range(0, 1));
         run_instr(o, f3, rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 3), 2);
      end

      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
